rom_readback: RTL and testbench

- Sequential reader for the ROM/PROM set already written by the download path.
- Walks the flat download address space from 0 to LAST_ADDR and issues reads to the port-a side of the ROM DPRAMs.
- Streams each returned byte out over a valid/ready handshake, for HPS upload or the on-core integrity check.
- Sits beside the loader, drives the read-side mux during a dump, and idles otherwise.

---
 rtl/rom_map_pkg.sv | 42 ++++
 rtl/rom_region_decode.sv | 26 ++
 rtl/rom_readback.sv | 164 ++++++++++++++++
 tb/tb_rom_readback.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_map_pkg.sv
// Flat download address map of the ROM/PROM set: region indices, region end
// addresses, the readback FSM state type and the checksum step.
package rom_map_pkg;

   typedef enum logic [3:0] {
      EP1   = 4'd0,
      EP2   = 4'd1,
      EP3   = 4'd2,
      EP4   = 4'd3,
      EP5   = 4'd4,
      EP6   = 4'd5,
      EP7   = 4'd6,
      EP8   = 4'd7,
      EP9   = 4'd8,
      EP10  = 4'd9,
      EP11  = 4'd10,
      EP12  = 4'd11,
      TLUT  = 4'd12,
      SLUT  = 4'd13,
      CPROM = 4'd14
   } rom_region_e;

   // Exclusive upper bounds; EP1..EP11 are uniform 8 KiB banks below EP11_END.
   localparam logic [24:0] EP11_END      = 25'h16000;
   localparam logic [24:0] EP12_END      = 25'h17000;
   localparam logic [24:0] TLUT_END      = 25'h17100;
   localparam logic [24:0] SLUT_END      = 25'h17200;
   localparam logic [24:0] ROM_LAST_ADDR = 25'h1721F;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ISSUE = 3'd1,
      ST_WAIT  = 3'd2,
      ST_HOLD  = 3'd3,
      ST_FIN   = 3'd4
   } rb_state_e;

   function automatic logic [15:0] cksum_add(input logic [15:0] sum, input logic [7:0] b);
      return sum + {8'h00, b};
   endfunction

endpackage

// File: rtl/rom_region_decode.sv
// Combinational flat address -> ROM region decode, shared by the readback
// mux and the loader-side chip selects.
module rom_region_decode
   import rom_map_pkg::*;
(
   input  logic [24:0] addr,
   output rom_region_e region
);

   // Below EP11_END the bank index is simply addr[16:13].
   always_comb begin
      region = CPROM;
      if (addr < EP11_END) begin
         region = rom_region_e'(addr[16:13]);
      end else if (addr < EP12_END) begin
         region = EP12;
      end else if (addr < TLUT_END) begin
         region = TLUT;
      end else if (addr < SLUT_END) begin
         region = SLUT;
      end else begin
         region = CPROM;
      end
   end

endmodule

// File: rtl/rom_readback.sv
// rom_readback: walks the flat ROM address space and streams each byte out
// over valid/ready. Define ROM_READBACK_CKSUM_EN for the running CKSUM sum.
module rom_readback
   import rom_map_pkg::*;
#(
   parameter logic [24:0] LAST_ADDR = ROM_LAST_ADDR,
   parameter int unsigned RD_LAT    = 1
) (
   input  logic        CLK,
   input  logic        RESET_N,
   input  logic        START,
   input  logic        ABORT,
   output logic [24:0] RD_ADDR,
   output logic [3:0]  RD_REGION,
   output logic        RD_EN,
   input  logic [7:0]  RD_DATA,
   output logic [7:0]  OUT_DATA,
   output logic [24:0] OUT_ADDR,
   output logic        OUT_VALID,
   input  logic        OUT_READY,
   output logic        BUSY,
   output logic        DONE,
   output logic [15:0] CKSUM
);

   localparam logic [1:0] RD_LAT_C = 2'(RD_LAT);

   rb_state_e   state_r, state_nxt_s;
   logic [24:0] addr_r, addr_nxt_s;
   rom_region_e region_r, region_s;
   logic [1:0]  lat_cnt_r, lat_cnt_nxt_s;
   logic [7:0]  out_data_r, out_data_nxt_s;
   logic [24:0] out_addr_r, out_addr_nxt_s;
   logic        out_valid_r, out_valid_nxt_s;
   logic        busy_r, done_r;
   logic        start_go_s, accept_s, lat_done_s;

   // ABORT wins over both START in IDLE and a same-cycle handshake in HOLD.
   assign start_go_s = (state_r == ST_IDLE) && START && !ABORT;
   assign accept_s   = (state_r == ST_HOLD) && OUT_READY && !ABORT;
   assign lat_done_s = (lat_cnt_r <= 2'd1);

   rom_region_decode u_region (
      .addr   (addr_nxt_s),
      .region (region_s)
   );

   // State register
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE:  if (start_go_s) state_nxt_s = ST_ISSUE; else state_nxt_s = ST_IDLE;
         ST_ISSUE: if (ABORT) state_nxt_s = ST_FIN; else state_nxt_s = ST_WAIT;
         ST_WAIT: begin
            if (ABORT)           state_nxt_s = ST_FIN;
            else if (lat_done_s) state_nxt_s = ST_HOLD;
            else                 state_nxt_s = ST_WAIT;
         end
         ST_HOLD: begin
            if (ABORT)                    state_nxt_s = ST_FIN;
            else if (!OUT_READY)          state_nxt_s = ST_HOLD;
            else if (addr_r == LAST_ADDR) state_nxt_s = ST_FIN;
            else                          state_nxt_s = ST_ISSUE;
         end
         ST_FIN:   state_nxt_s = ST_IDLE;
         default:  state_nxt_s = ST_IDLE;
      endcase
   end

   // Next values of the address counter, latency counter and output byte
   always_comb begin
      addr_nxt_s      = addr_r;
      lat_cnt_nxt_s   = lat_cnt_r;
      out_data_nxt_s  = out_data_r;
      out_addr_nxt_s  = out_addr_r;
      out_valid_nxt_s = out_valid_r;
      case (state_r)
         ST_IDLE: begin
            if (start_go_s) addr_nxt_s = 25'd0; else addr_nxt_s = addr_r;
         end
         ST_ISSUE: lat_cnt_nxt_s = RD_LAT_C;
         ST_WAIT: begin
            lat_cnt_nxt_s = lat_cnt_r - 2'd1;
            if (!ABORT && lat_done_s) begin
               out_data_nxt_s  = RD_DATA;
               out_addr_nxt_s  = addr_r;
               out_valid_nxt_s = 1'b1;
            end else begin
               out_valid_nxt_s = 1'b0;
            end
         end
         ST_HOLD: begin
            if (accept_s || ABORT) out_valid_nxt_s = 1'b0; else out_valid_nxt_s = out_valid_r;
            if (accept_s && (addr_r != LAST_ADDR)) addr_nxt_s = addr_r + 25'd1;
            else addr_nxt_s = addr_r;
         end
         ST_FIN:  out_valid_nxt_s = 1'b0;
         default: out_valid_nxt_s = 1'b0;
      endcase
   end

   // Output and datapath registers
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         addr_r      <= 25'd0;
         region_r    <= EP1;
         lat_cnt_r   <= 2'd0;
         out_data_r  <= 8'h00;
         out_addr_r  <= 25'd0;
         out_valid_r <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
      end else begin
         addr_r      <= addr_nxt_s;
         region_r    <= region_s;
         lat_cnt_r   <= lat_cnt_nxt_s;
         out_data_r  <= out_data_nxt_s;
         out_addr_r  <= out_addr_nxt_s;
         out_valid_r <= out_valid_nxt_s;
         busy_r      <= (state_nxt_s != ST_IDLE);
         done_r      <= (state_nxt_s == ST_FIN);
      end
   end

`ifdef ROM_READBACK_CKSUM_EN
   logic [15:0] cksum_r;

   // Running sum of accepted bytes, restarted by the START that opens a dump
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         cksum_r <= 16'h0000;
      end else if (start_go_s) begin
         cksum_r <= 16'h0000;
      end else if (accept_s) begin
         cksum_r <= cksum_add(cksum_r, out_data_r);
      end else begin
         cksum_r <= cksum_r;
      end
   end

   assign CKSUM = cksum_r;
`else
   assign CKSUM = 16'h0000;
`endif

   assign RD_ADDR   = addr_r;
   assign RD_REGION = region_r;
   assign RD_EN     = busy_r;
   assign BUSY      = busy_r;
   assign DONE      = done_r;
   assign OUT_DATA  = out_data_r;
   assign OUT_ADDR  = out_addr_r;
   assign OUT_VALID = out_valid_r;

endmodule

// File: tb/tb_rom_readback.sv
// Bench for rom_readback: three instances (full map/RD_LAT=1, RD_LAT=3, 16-byte map)
// checked against an address-sequence model of the dump.
module tb_rom_readback;

   localparam int LAST0 = 'h1721F;
   localparam int LAST1 = 'h3F;
   localparam int LAST2 = 'hF;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic        start_v   [3];
   logic        abort_v   [3];
   logic        ready_v   [3];
   logic [24:0] rd_addr   [3];
   logic [3:0]  rd_region [3];
   logic        rd_en     [3];
   logic [7:0]  out_data  [3];
   logic [24:0] out_addr  [3];
   logic        out_valid [3];
   logic        busy      [3];
   logic        done      [3];
   logic [15:0] cksum     [3];
   logic [7:0]  p1 [3];
   logic [7:0]  p2 [3];
   logic [7:0]  p3 [3];
   logic [24:0] dec_addr;
   logic [3:0]  dec_region;

   int n_run  = 0;
   int n_fail = 0;
   int exp_addr;
   int sum;

   always #5 clk = ~clk;

   rom_readback #(.LAST_ADDR(25'h1721F), .RD_LAT(1)) u_dut0 (
      .CLK(clk), .RESET_N(rst_n), .START(start_v[0]), .ABORT(abort_v[0]),
      .RD_ADDR(rd_addr[0]), .RD_REGION(rd_region[0]), .RD_EN(rd_en[0]), .RD_DATA(p1[0]),
      .OUT_DATA(out_data[0]), .OUT_ADDR(out_addr[0]), .OUT_VALID(out_valid[0]),
      .OUT_READY(ready_v[0]), .BUSY(busy[0]), .DONE(done[0]), .CKSUM(cksum[0]));

   rom_readback #(.LAST_ADDR(25'h0003F), .RD_LAT(3)) u_dut1 (
      .CLK(clk), .RESET_N(rst_n), .START(start_v[1]), .ABORT(abort_v[1]),
      .RD_ADDR(rd_addr[1]), .RD_REGION(rd_region[1]), .RD_EN(rd_en[1]), .RD_DATA(p3[1]),
      .OUT_DATA(out_data[1]), .OUT_ADDR(out_addr[1]), .OUT_VALID(out_valid[1]),
      .OUT_READY(ready_v[1]), .BUSY(busy[1]), .DONE(done[1]), .CKSUM(cksum[1]));

   rom_readback #(.LAST_ADDR(25'h0000F), .RD_LAT(1)) u_dut2 (
      .CLK(clk), .RESET_N(rst_n), .START(start_v[2]), .ABORT(abort_v[2]),
      .RD_ADDR(rd_addr[2]), .RD_REGION(rd_region[2]), .RD_EN(rd_en[2]), .RD_DATA(p1[2]),
      .OUT_DATA(out_data[2]), .OUT_ADDR(out_addr[2]), .OUT_VALID(out_valid[2]),
      .OUT_READY(ready_v[2]), .BUSY(busy[2]), .DONE(done[2]), .CKSUM(cksum[2]));

   rom_region_decode u_dec (.addr(dec_addr), .region(dec_region));

   function automatic logic [7:0] rom_byte(input logic [24:0] a);
      return a[7:0] ^ a[15:8];
   endfunction

   function automatic int model_region(input int a);
      if (a < 'h16000) return a / 'h2000;
      if (a < 'h17000) return 11;
      if (a < 'h17100) return 12;
      if (a < 'h17200) return 13;
      return 14;
   endfunction

   function automatic logic [15:0] exp_cksum();
`ifdef ROM_READBACK_CKSUM_EN
      return sum[15:0];
`else
      return 16'h0000;
`endif
   endfunction

   // ROM model: q follows the address through a 3-deep pipeline, tapped per latency
   always @(posedge clk) begin
      for (int k = 0; k < 3; k++) begin
         p1[k] <= rom_byte(rd_addr[k]);
         p2[k] <= p1[k];
         p3[k] <= p2[k];
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_dump(input int k);
      exp_addr   = 0;
      sum        = 0;
      start_v[k] = 1'b1;
      tick();
      start_v[k] = 1'b0;
      n_run++;
      if (busy[k] !== 1'b1 || rd_en[k] !== 1'b1 || cksum[k] !== 16'h0000 || rd_addr[k] !== 25'd0) begin
         n_fail++;
         $display("FAIL start dut%0d got busy=%b rd_en=%b cksum=%h rd_addr=%h expected 1 1 0000 0",
                  k, busy[k], rd_en[k], cksum[k], rd_addr[k]);
      end
   endtask

   // Follows the stream until DONE, or returns while presenting stop_addr (not accepted)
   task automatic stream(input int k, input int last, input int lat, input int stop_addr, input bit rnd);
      int cyc = 0;
      int last_cyc = -1;
      while (cyc < 40000) begin
         ready_v[k] = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
         if (done[k]) begin
            n_run++;
            if (exp_addr != last + 1 || out_valid[k] !== 1'b0 || cksum[k] !== exp_cksum()) begin
               n_fail++;
               $display("FAIL done dut%0d got bytes=%0d valid=%b cksum=%h expected bytes=%0d valid=0 cksum=%h",
                        k, exp_addr, out_valid[k], cksum[k], last + 1, exp_cksum());
            end
            ready_v[k] = 1'b0;
            tick();
            n_run++;
            if (done[k] !== 1'b0 || busy[k] !== 1'b0) begin
               n_fail++;
               $display("FAIL after_done dut%0d got done=%b busy=%b expected 0 0", k, done[k], busy[k]);
            end
            return;
         end
         if (out_valid[k]) begin
            n_run++;
            if (out_addr[k] !== 25'(exp_addr) || out_data[k] !== rom_byte(25'(exp_addr)) ||
                rd_region[k] !== 4'(model_region(exp_addr))) begin
               n_fail++;
               $display("FAIL byte dut%0d got addr=%h data=%h region=%0d expected addr=%h data=%h region=%0d",
                        k, out_addr[k], out_data[k], rd_region[k], exp_addr,
                        rom_byte(25'(exp_addr)), model_region(exp_addr));
            end
            if (!rnd && last_cyc >= 0) begin
               n_run++;
               if (cyc - last_cyc != lat + 2) begin
                  n_fail++;
                  $display("FAIL spacing dut%0d got %0d cycles expected %0d", k, cyc - last_cyc, lat + 2);
               end
            end
            last_cyc = cyc;
            if (exp_addr == stop_addr) begin
               ready_v[k] = 1'b0;
               return;
            end
            if (ready_v[k]) begin
               sum += int'(rom_byte(25'(exp_addr)));
               exp_addr++;
            end
         end
         tick();
         cyc++;
      end
      n_run++;
      n_fail++;
      $display("FAIL timeout dut%0d got no DONE/stop expected one at addr %h", k, exp_addr);
   endtask

   task automatic abort_dump(input int k, input bit rdy);
      abort_v[k] = 1'b1;
      ready_v[k] = rdy;
      tick();
      abort_v[k] = 1'b0;
      ready_v[k] = 1'b0;
      n_run++;
      if (out_valid[k] !== 1'b0 || done[k] !== 1'b1 || busy[k] !== 1'b1 || cksum[k] !== exp_cksum()) begin
         n_fail++;
         $display("FAIL abort dut%0d got valid=%b done=%b busy=%b cksum=%h expected 0 1 1 %h",
                  k, out_valid[k], done[k], busy[k], cksum[k], exp_cksum());
      end
      tick();
      n_run++;
      if (done[k] !== 1'b0 || busy[k] !== 1'b0 || rd_en[k] !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_idle dut%0d got done=%b busy=%b rd_en=%b expected 0 0 0", k, done[k], busy[k], rd_en[k]);
      end
   endtask

   task automatic test_reset();
      logic [81:0] v;
      rst_n = 1'b0;
      tick();
      tick();
      for (int k = 0; k < 3; k++) begin
         v = {rd_addr[k], rd_region[k], rd_en[k], out_data[k], out_addr[k], out_valid[k], busy[k], done[k], cksum[k]};
         n_run++;
         if (v !== 82'd0) begin
            n_fail++;
            $display("FAIL reset_state dut%0d got %h expected 0", k, v);
         end
      end
      rst_n = 1'b1;
      tick();
      start_dump(0);
      stream(0, LAST0, 1, 'h10, 1'b0);
      rst_n = 1'b0;
      #1;
      v = {rd_addr[0], rd_region[0], rd_en[0], out_data[0], out_addr[0], out_valid[0], busy[0], done[0], cksum[0]};
      n_run++;
      if (v !== 82'd0) begin
         n_fail++;
         $display("FAIL reset_mid_hold got %h expected 0", v);
      end
      tick();
      n_run++;
      if (done[0] !== 1'b0 || busy[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_no_done got done=%b busy=%b expected 0 0", done[0], busy[0]);
      end
      rst_n = 1'b1;
      tick();
      start_dump(0);
      stream(0, LAST0, 1, 'h2, 1'b0);
      abort_dump(0, 1'b0);
   endtask

   task automatic test_start_abort_idle();
      start_v[2] = 1'b1;
      abort_v[2] = 1'b1;
      tick();
      start_v[2] = 1'b0;
      abort_v[2] = 1'b0;
      for (int i = 0; i < 2; i++) begin
         n_run++;
         if (busy[2] !== 1'b0 || done[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL start_abort_idle cycle%0d got busy=%b done=%b expected 0 0", i, busy[2], done[2]);
         end
         tick();
      end
   endtask

   task automatic test_region_decode();
      int addrs [13] = '{'h0, 'h1FFF, 'h2000, 'h15FFF, 'h16000, 'h16FFF, 'h17000,
                         'h170FF, 'h17100, 'h171FF, 'h17200, 'h1721F, 'h1FFFFFF};
      int a;
      for (int i = 0; i < 33; i++) begin
         a = (i < 13) ? addrs[i] : int'($urandom_range(0, 'h18000));
         dec_addr = 25'(a);
         #1;
         n_run++;
         if (dec_region !== 4'(model_region(a))) begin
            n_fail++;
            $display("FAIL region addr=%h got %0d expected %0d", a, dec_region, model_region(a));
         end
      end
   endtask

   task automatic test_short_dump();
      start_dump(2);
      stream(2, LAST2, 1, -1, 1'b0);
      start_dump(2);
      stream(2, LAST2, 1, -1, 1'b1);
   endtask

   task automatic test_rd_lat3();
      start_dump(1);
      stream(1, LAST1, 3, -1, 1'b0);
      start_dump(1);
      stream(1, LAST1, 3, -1, 1'b1);
   endtask

   task automatic test_abort();
      start_dump(0);
      stream(0, LAST0, 1, 'h80, 1'b0);
      start_v[0] = 1'b1;
      ready_v[0] = 1'b1;
      sum += int'(rom_byte(25'h80));
      exp_addr++;
      tick();
      start_v[0] = 1'b0;
      ready_v[0] = 1'b0;
      stream(0, LAST0, 1, 'h100, 1'b0);
      abort_dump(0, 1'b1);
   endtask

   task automatic test_backpressure();
      start_dump(0);
      stream(0, LAST0, 1, 'h1FFF, 1'b0);
      for (int i = 0; i < 5; i++) begin
         ready_v[0] = 1'b0;
         tick();
         n_run++;
         if (out_valid[0] !== 1'b1 || out_addr[0] !== 25'h01FFF || out_data[0] !== 8'hE0) begin
            n_fail++;
            $display("FAIL backpressure_hold got valid=%b addr=%h data=%h expected 1 01fff e0",
                     out_valid[0], out_addr[0], out_data[0]);
         end
      end
      ready_v[0] = 1'b1;
      sum += int'(rom_byte(25'h1FFF));
      exp_addr++;
      tick();
      ready_v[0] = 1'b0;
      n_run++;
      if (out_valid[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL backpressure_release got valid=%b expected 0", out_valid[0]);
      end
      stream(0, LAST0, 1, 'h2000, 1'b0);
      n_run++;
      if (rd_region[0] !== 4'd1 || out_addr[0] !== 25'h02000) begin
         n_fail++;
         $display("FAIL resume_region got region=%0d addr=%h expected 1 02000", rd_region[0], out_addr[0]);
      end
      abort_dump(0, 1'b0);
   endtask

   initial begin
      for (int k = 0; k < 3; k++) begin
         start_v[k] = 1'b0;
         abort_v[k] = 1'b0;
         ready_v[k] = 1'b0;
      end
      dec_addr = 25'd0;
      test_reset();
      test_start_abort_idle();
      test_region_decode();
      test_short_dump();
      test_rd_lat3();
      test_abort();
      test_backpressure();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog got no finish expected end of tests");
      $fatal(1);
   end

endmodule
